alu_exec_unit: RTL and testbench

Integer functional unit on the execute side of the reservation-station dispatch interface. It accepts one issued operation per dispatch from its reservation station (two operand values, opcode, ROB index), computes the result, and broadcasts it on the common data bus (CDB). Single-cycle ALU operations complete in one cycle; MUL runs on an iterative multiplier. An in-order result FIFO absorbs CDB arbitration stalls. Back-pressure to the reservation station is through `fu_busy`.

---
 rtl/alu_exec_unit_pkg.sv | 48 ++++
 rtl/alu_exec_unit_seq_multiplier.sv | 58 +++++
 rtl/alu_exec_unit.sv | 139 +++++++++++++
 tb/tb_alu_exec_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared integer-unit types: AluFunc encoding, widths
// and the single-cycle ALU datapath function.
package alu_exec_unit_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_func_e;

  // Mul and the unused codes fall to zero here
  function automatic logic [XLEN-1:0] alu_calc(
    input logic [3:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    logic [4:0]      sh;
    sh = b[4:0];
    r  = '0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: r = XLEN'(a < b);
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = $unsigned($signed(a) >>> sh);
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Radix-2 shift-add multiplier; done and product
// present the final step combinationally.
module seq_multiplier
  import alu_exec_unit_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int CNTW = $clog2(STEPS);

  logic            busy_q;
  logic [CNTW-1:0] cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] step_acc;
  logic            last;

  assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last      = cnt_q == CNTW'(STEPS - 1);
  assign done_o    = busy_q && last;
  assign product_o = step_acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= step_acc;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute unit: ALU + iterative MUL feeding
// an in-order result FIFO toward the CDB.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int RES_DEPTH  = 4,
  parameter int MUL_CYCLES = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [XLEN-1:0]      rval1_in,
  input  logic [XLEN-1:0]      rval2_in,
  input  logic [3:0]           opcode_in,
  input  logic [ROB_IDX_W-1:0] rob_idx_in,
  output logic                 fu_busy,
  output logic                 cdb_valid_out,
  output logic [XLEN-1:0]      cdb_value_out,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx_out,
  input  logic                 cdb_grant_in
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = $clog2(RES_DEPTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e               state_q, state_d;
  logic [ROB_IDX_W-1:0] mul_rob_q, mul_rob_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [XLEN-1:0]      val_mem [RES_DEPTH];
  logic [ROB_IDX_W-1:0] rob_mem [RES_DEPTH];

  logic                 is_mul;
  logic                 push, pop;
  logic                 mul_start, mul_done;
  logic [XLEN-1:0]      push_val, mul_prod;
  logic [ROB_IDX_W-1:0] push_rob;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_mul = opcode_in == ALU_MUL;

  seq_multiplier #(
    .STEPS(MUL_CYCLES)
  ) u_mul (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .start_i  (mul_start),
    .a_i      (rval1_in),
    .b_i      (rval2_in),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    mul_rob_d = mul_rob_q;
    mul_start = 1'b0;
    push      = 1'b0;
    push_val  = '0;
    push_rob  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_in && is_mul) begin
          mul_start = 1'b1;
          mul_rob_d = rob_idx_in;
          state_d   = S_MUL;
        end else if (valid_in) begin
          push     = 1'b1;
          push_val = alu_calc(opcode_in, rval1_in, rval2_in);
          push_rob = rob_idx_in;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          push     = 1'b1;
          push_val = mul_prod;
          push_rob = mul_rob_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = (count_q != '0) && cdb_grant_in;
    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
  end

  // Threshold leaves one slot free for a Mul in flight
  assign fu_busy = rst_in
                 || (state_q == S_MUL)
                 || (valid_in && is_mul)
                 || (count_d >= CW'(RES_DEPTH - 1));

  assign cdb_valid_out   = count_q != '0;
  assign cdb_value_out   = cdb_valid_out ? val_mem[rptr_q] : '0;
  assign cdb_rob_idx_out = cdb_valid_out ? rob_mem[rptr_q] : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      mul_rob_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mul_rob_q <= mul_rob_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      val_mem[wptr_q] <= push_val;
      rob_mem[wptr_q] <= push_rob;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_in) disable iff (rst_in)
    !(push && !pop && count_q == CW'(RES_DEPTH))
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: random and
// directed dispatches against a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] rval1_in = '0;
  logic [31:0] rval2_in = '0;
  logic [3:0]  opcode_in = '0;
  logic [2:0]  rob_idx_in = '0;
  logic        fu_busy;
  logic        cdb_valid_out;
  logic [31:0] cdb_value_out;
  logic [2:0]  cdb_rob_idx_out;
  logic        cdb_grant_in = 1'b0;

  typedef struct packed {
    logic [2:0]  rob;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rand_grant = 1'b0;

  alu_exec_unit #(
    .RES_DEPTH (4),
    .MUL_CYCLES(32)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .rval1_in       (rval1_in),
    .rval2_in       (rval2_in),
    .opcode_in      (opcode_in),
    .rob_idx_in     (rob_idx_in),
    .fu_busy        (fu_busy),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_value_out  (cdb_value_out),
    .cdb_rob_idx_out(cdb_rob_idx_out),
    .cdb_grant_in   (cdb_grant_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_calc(
    input int op, input logic [31:0] a, input logic [31:0] b
  );
    int          s;
    logic [31:0] ones;
    logic [31:0] r;
    logic [63:0] p;
    s    = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7: return a << s;
      8: return a >> s;
      9: begin
        r = a >> s;
        if (a[31]) r = r | ~(ones >> s);
        return r;
      end
      10: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Dispatch only after fu_busy was seen low before an edge
  task automatic issue(input int op, input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [2:0] rob);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (fu_busy && n < 500) begin
      step();
      valid_in = 1'b0;
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: fu_busy stuck high");
    end
    step();
    valid_in   = 1'b1;
    opcode_in  = 4'(op);
    rval1_in   = a;
    rval2_in   = b;
    rob_idx_in = rob;
    e.rob = rob;
    e.val = ref_calc(op, a, b);
    exp_q.push_back(e);
  endtask

  task automatic finish_issue();
    step();
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cdb_valid_out) && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 400) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding",
               exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst_in) begin
      if (cdb_valid_out && cdb_grant_in) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: rob %0d value %h",
                   cdb_rob_idx_out, cdb_value_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cdb_value_out !== e.val ||
              cdb_rob_idx_out !== e.rob) begin
            n_fail++;
            $display("FAIL cdb_result: got rob %0d %h expected rob %0d %h",
                     cdb_rob_idx_out, cdb_value_out, e.rob, e.val);
          end
        end
      end else if (!cdb_valid_out) begin
        n_chk++;
        if (cdb_value_out !== '0 || cdb_rob_idx_out !== '0) begin
          n_fail++;
          $display("FAIL empty_head: got rob %0d %h expected 0 0",
                   cdb_rob_idx_out, cdb_value_out);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rand_grant) begin
        #1;
        cdb_grant_in = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int early;
    int op;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(cdb_valid_out), 32'd0);
    chk("reset_value", cdb_value_out, 32'd0);
    chk("reset_rob", 32'(cdb_rob_idx_out), 32'd0);
    chk("reset_busy", 32'(fu_busy), 32'd1);
    step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(fu_busy), 32'd0);

    // Add latency, no bypass
    step();
    cdb_grant_in = 1'b1;
    issue(0, 32'd7, 32'd5, 3'd3);
    @(negedge clk);
    chk("add_not_yet", 32'(cdb_valid_out), 32'd0);
    finish_issue();
    @(negedge clk);
    chk("add_valid", 32'(cdb_valid_out), 32'd1);
    chk("add_value", cdb_value_out, 32'd12);
    chk("add_rob", 32'(cdb_rob_idx_out), 32'd3);
    @(negedge clk);
    chk("add_popped", 32'(cdb_valid_out), 32'd0);

    // Shifts, compares, illegal code, back to back
    issue(9, 32'h8000_0000, 32'd4, 3'd1);
    issue(8, 32'h8000_0000, 32'd4, 3'd2);
    issue(5, 32'hFFFF_FFFF, 32'd1, 3'd3);
    issue(6, 32'hFFFF_FFFF, 32'd1, 3'd4);
    issue(13, 32'h1234_5678, 32'd9, 3'd5);
    finish_issue();
    wait_drain();

    // Mul latency and busy window
    step();
    issue(10, 32'd6, 32'd7, 3'd5);
    busy_n = 0;
    early = 0;
    @(negedge clk);
    if (fu_busy) busy_n++;
    finish_issue();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!fu_busy) break;
      busy_n++;
      if (cdb_valid_out) early++;
    end
    chk("mul_busy_cycles", 32'(busy_n), 32'd33);
    chk("mul_no_early", 32'(early), 32'd0);
    chk("mul_valid", 32'(cdb_valid_out), 32'd1);
    chk("mul_value", cdb_value_out, 32'd42);
    chk("mul_rob", 32'(cdb_rob_idx_out), 32'd5);
    issue(10, 32'hFFFF_FFFF, 32'd2, 3'd6);
    finish_issue();
    wait_drain();

    // Back-pressure with grant low
    step();
    cdb_grant_in = 1'b0;
    issue(0, 32'd100, 32'd1, 3'd0);
    issue(1, 32'd100, 32'd1, 3'd1);
    issue(4, 32'hF0F0, 32'hFF, 3'd2);
    @(negedge clk);
    chk("bp_busy_rise", 32'(fu_busy), 32'd1);
    finish_issue();
    @(negedge clk);
    chk("bp_busy_full", 32'(fu_busy), 32'd1);
    chk("bp_head_rob", 32'(cdb_rob_idx_out), 32'd0);
    repeat (5) step();
    chk("bp_busy_hold", 32'(fu_busy), 32'd1);
    step();
    cdb_grant_in = 1'b1;
    wait_drain();

    // Simultaneous push and pop with one entry held
    step();
    cdb_grant_in = 1'b0;
    issue(3, 32'h00FF_0000, 32'h0000_00FF, 3'd4);
    finish_issue();
    issue(7, 32'h1, 32'd31, 3'd6);
    cdb_grant_in = 1'b1;
    @(negedge clk);
    chk("pp_head_old", 32'(cdb_rob_idx_out), 32'd4);
    finish_issue();
    cdb_grant_in = 1'b0;
    @(negedge clk);
    chk("pp_valid", 32'(cdb_valid_out), 32'd1);
    chk("pp_head_new", 32'(cdb_rob_idx_out), 32'd6);
    chk("pp_value_new", cdb_value_out, 32'h8000_0000);
    step();
    cdb_grant_in = 1'b1;
    step();
    @(negedge clk);
    chk("pp_count_one", 32'(cdb_valid_out), 32'd0);

    // Reset during a Mul with the FIFO occupied
    step();
    cdb_grant_in = 1'b0;
    issue(0, 32'd1, 32'd2, 3'd1);
    issue(10, $urandom, $urandom, 3'd2);
    finish_issue();
    repeat (9) step();
    rst_in = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", 32'(cdb_valid_out), 32'd0);
    chk("rst_mid_busy", 32'(fu_busy), 32'd1);
    repeat (2) step();
    rst_in = 1'b0;
    cdb_grant_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_stale", 32'(cdb_valid_out), 32'd0);
    issue(0, 32'd20, 32'd22, 3'd7);
    finish_issue();
    wait_drain();

    // Randomized traffic with random grant
    step();
    rand_grant = 1'b1;
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 15);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ?
           32'($urandom_range(0, 40)) : $urandom;
      issue(op, a, b, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) finish_issue();
    end
    finish_issue();
    rand_grant = 1'b0;
    step();
    cdb_grant_in = 1'b1;
    wait_drain();

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
